// File: rtl/canden_ctrl_pkg.sv
// Shared types for the CANDEN enable sequencer.
package canden_ctrl_pkg;

  localparam int STATE_W = 2;

  // Encodings are visible on the STATE pins, so they are fixed.
  typedef enum logic [STATE_W-1:0] {
    ST_OFF  = 2'b00,
    ST_WAKE = 2'b01,
    ST_ON   = 2'b10,
    ST_IDLE = 2'b11
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/canden_ctrl_cnt.sv
// Loadable down-counter with a zero flag; decrement saturates at 0.
module canden_ctrl_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load wins over decrement; never wrap below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/canden_ctrl.sv
// Enable sequencer for a CANDEN clock-gate cell. All pin outputs are
// registered so the gate enables cannot glitch.
//
// state | meaning
// OFF   | gated clock stopped; DEN tracks mode_dyn_i
// WAKE  | gate enabled, waiting for the clock to settle
// ON    | clock running, domain kept alive by request/activity
// IDLE  | clock running, counting down to gate-off
module canden_ctrl
  import canden_ctrl_pkg::*;
#(
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_en_i,
  input  logic               activity_i,
  input  logic               force_on_i,
  input  logic               mode_dyn_i,
  output logic               sen_o,
  output logic               den_o,
  output logic               dynen_o,
  output logic               clk_on_o,
  output logic [STATE_W-1:0] state_o
);

  localparam int MAX_C = max_int(WAKE_CYCLES, IDLE_CYCLES);

  if (WAKE_CYCLES < 1) begin : g_bad_wake
    $error("canden_ctrl: WAKE_CYCLES must be >= 1");
  end
  if (IDLE_CYCLES < 1) begin : g_bad_idle
    $error("canden_ctrl: IDLE_CYCLES must be >= 1");
  end
  if ((longint'(MAX_C) - 1) >= (longint'(1) << CNT_W)) begin : g_bad_cnt
    $error("canden_ctrl: CNT_W too narrow for the cycle counts");
  end

  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic             den_q, den_d;
  logic             sen_q, sen_d;
  logic             dynen_q, dynen_d;
  logic             clk_on_q, clk_on_d;
  logic             gate_en;
  logic             wake, keep;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;

  assign wake = req_en_i | force_on_i;
  assign keep = req_en_i | force_on_i | activity_i;

  canden_ctrl_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // State and output registers; reset forces OFF from any state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_OFF;
      den_q    <= 1'b0;
      sen_q    <= 1'b0;
      dynen_q  <= 1'b0;
      clk_on_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      den_q    <= den_d;
      sen_q    <= sen_d;
      dynen_q  <= dynen_d;
      clk_on_q <= clk_on_d;
    end
  end

  // Next state, counter control and DEN sampling (only while OFF).
  always_comb begin
    state_d      = state_q;
    den_d        = den_q;
    cnt_load     = 1'b0;
    cnt_load_val = WAKE_LOAD;
    cnt_dec      = 1'b0;
    unique case (state_q)
      ST_OFF: begin
        den_d = mode_dyn_i;
        if (wake) begin
          state_d      = ST_WAKE;
          cnt_load     = 1'b1;
          cnt_load_val = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        if (cnt_zero) begin
          state_d = ST_ON;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_ON: begin
        if (!keep) begin
          state_d      = ST_IDLE;
          cnt_load     = 1'b1;
          cnt_load_val = IDLE_LOAD;
        end
      end
      ST_IDLE: begin
        if (keep) begin
          state_d = ST_ON;
        end else if (cnt_zero) begin
          state_d = ST_OFF;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Output decode from the next state so the pins change on the state edge.
  always_comb begin
    gate_en  = (state_d != ST_OFF);
    sen_d    = gate_en & ~den_d;
    dynen_d  = gate_en & den_d;
    clk_on_d = (state_d == ST_ON) || (state_d == ST_IDLE);
  end

  assign sen_o    = sen_q;
  assign den_o    = den_q;
  assign dynen_o  = dynen_q;
  assign clk_on_o = clk_on_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_canden_ctrl.sv
// Scoreboard bench for canden_ctrl: directed scenarios then random segments,
// checked against a cycle-count reference model.
module tb_canden_ctrl;

  localparam int WAKE = 2;
  localparam int IDLE = 16;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       req_en_i = 1'b0;
  logic       activity_i = 1'b0;
  logic       force_on_i = 1'b0;
  logic       mode_dyn_i = 1'b0;
  logic       sen_o, den_o, dynen_o, clk_on_o;
  logic [1:0] state_o;

  canden_ctrl #(
    .WAKE_CYCLES (WAKE),
    .IDLE_CYCLES (IDLE),
    .CNT_W       (8)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .req_en_i   (req_en_i),
    .activity_i (activity_i),
    .force_on_i (force_on_i),
    .mode_dyn_i (mode_dyn_i),
    .sen_o      (sen_o),
    .den_o      (den_o),
    .dynen_o    (dynen_o),
    .clk_on_o   (clk_on_o),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] state;
    logic       sen;
    logic       den;
    logic       dynen;
    logic       clk_on;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  bit   stim_done = 1'b0;

  // Reference model: gate on/off, cycles elapsed since gating on,
  // and length of the current run of non-keep cycles.
  bit m_on   = 1'b0;
  bit m_den  = 1'b0;
  int m_el   = 0;
  int m_idle = 0;

  function automatic exp_t model_out();
    exp_t e;
    if (!m_on)             e.state = 2'b00;
    else if (m_el < WAKE)  e.state = 2'b01;
    else if (m_idle == 0)  e.state = 2'b10;
    else                   e.state = 2'b11;
    e.den    = m_den;
    e.sen    = m_on & ~m_den;
    e.dynen  = m_on & m_den;
    e.clk_on = m_on && (m_el >= WAKE);
    return e;
  endfunction

  task automatic model_step(input bit rst, input bit req, input bit act,
                            input bit frc, input bit mode);
    bit wake, keep;
    wake = req | frc;
    keep = req | frc | act;
    if (rst) begin
      m_on = 0; m_den = 0; m_el = 0; m_idle = 0;
    end else if (!m_on) begin
      m_den = mode;
      if (wake) begin
        m_on = 1; m_el = 0; m_idle = 0;
      end
    end else if (m_el < WAKE) begin
      m_el++;
    end else if (keep) begin
      m_idle = 0;
    end else if (m_idle == IDLE) begin
      m_on = 0;
    end else begin
      m_idle++;
    end
  endtask

  // Apply one cycle of inputs (called at negedge) and queue the expected result.
  task automatic drive(input bit rst, input bit req, input bit act,
                       input bit frc, input bit mode);
    rst_i      = rst;
    req_en_i   = req;
    activity_i = act;
    force_on_i = frc;
    mode_dyn_i = mode;
    model_step(rst, req, act, frc, mode);
    exp_q.push_back(model_out());
  endtask

  task automatic cyc(input int n, input bit rst, input bit req, input bit act,
                     input bit frc, input bit mode);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(rst, req, act, frc, mode);
    end
  endtask

  // Monitor: every cycle the DUT presents a result, compare with the queue head.
  initial begin : monitor
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{state: state_o, sen: sen_o, den: den_o, dynen: dynen_o, clk_on: clk_on_o};
        n_total++;
        if (a === e) begin
          n_pass++;
        end else begin
          $display("FAIL outputs t=%0t got state=%b sen=%b den=%b dynen=%b clk_on=%b expected state=%b sen=%b den=%b dynen=%b clk_on=%b",
                   $time, a.state, a.sen, a.den, a.dynen, a.clk_on,
                   e.state, e.sen, e.den, e.dynen, e.clk_on);
        end
      end
    end
  end

  initial begin : stimulus
    int seg_len, p_req, p_act, p_frc, p_mode, p_rst;
    bit mode;
    // 1: reset
    cyc(3, 1, 0, 0, 0, 0);
    cyc(2, 0, 0, 0, 0, 0);
    // 2/3: static wake, hold, idle timeout to OFF
    cyc(10, 0, 1, 0, 0, 0);
    cyc(IDLE + 3, 0, 0, 0, 0, 0);
    // 4: activity at counter=5 restarts; expiry coincident with activity stays ON
    cyc(6, 0, 1, 0, 0, 0);
    cyc(11, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    cyc(IDLE, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    cyc(IDLE + 2, 0, 0, 0, 0, 0);
    // 5: dynamic mode, mode toggling while ON
    cyc(2, 0, 0, 0, 0, 1);
    cyc(5, 0, 1, 0, 0, 1);
    cyc(3, 0, 1, 0, 0, 0);
    cyc(2, 0, 1, 0, 0, 1);
    cyc(IDLE + 3, 0, 0, 0, 0, 0);
    // 6: reset in WAKE, reset in IDLE, force-on hold
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(4, 0, 1, 0, 0, 0);
    cyc(5, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(40, 0, 0, 0, 1, 0);
    cyc(IDLE + 3, 0, 0, 0, 0, 0);
    // Random segments with varying input biases
    for (int s = 0; s < 60; s++) begin
      seg_len = $urandom_range(80, 20);
      p_req   = $urandom_range(70);
      p_act   = $urandom_range(60);
      p_frc   = $urandom_range(10);
      p_mode  = $urandom_range(20);
      p_rst   = $urandom_range(3);
      mode    = $urandom_range(1);
      for (int i = 0; i < seg_len; i++) begin
        if ($urandom_range(99) < p_mode) mode = ~mode;
        cyc(1, ($urandom_range(199) < p_rst),
               ($urandom_range(99) < p_req),
               ($urandom_range(99) < p_act),
               ($urandom_range(99) < p_frc),
               mode);
      end
    end
    cyc(3, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (exp_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain got %0d pending expected 0 pending", exp_q.size());
    end
    stim_done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog got timeout expected stimulus complete");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "timeout");
  end

endmodule
